adc_sar_ctrl: RTL and testbench



---
 rtl/adc_sar_pkg.sv | 15 +
 rtl/adc_sar_ctrl.sv | 148 ++++++++++++++
 tb/tb_adc_sar_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sar_pkg.sv
// Shared types and default constants for the SAR ADC controller.
package adc_sar_pkg;

    localparam int unsigned ADC_SAR_N             = 12;
    localparam int unsigned ADC_SAR_SAMPLE_CYCLES = 4;
    localparam int unsigned ADC_SAR_TIMEOUT       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } adc_sar_state_t;

endpackage

// File: rtl/adc_sar_ctrl.sv
// Successive-approximation controller: sample phase, binary search on the DAC
// code, one comparator strobe per bit, result delivered over valid/ready.
module adc_sar_ctrl
    import adc_sar_pkg::*;
#(
    parameter int unsigned N             = ADC_SAR_N,
    parameter int unsigned SAMPLE_CYCLES = ADC_SAR_SAMPLE_CYCLES,
    parameter int unsigned TIMEOUT       = ADC_SAR_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cont,
    input  logic         clr_flags,
    output logic         ms_adc_sample,
    output logic [N-1:0] ms_adc_dac,
    output logic         ms_adc_clk,
    input  logic         ms_adc_rdy,
    input  logic         ms_adc_cmp,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         overrun,
    output logic         err_timeout
);

    localparam int unsigned PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SCNT_W = $clog2(SAMPLE_CYCLES + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] BIT0  = N'(1);

    adc_sar_state_t      state, state_d;
    logic [SCNT_W-1:0]   samp_cnt, samp_cnt_d;
    logic [PTR_W-1:0]    ptr, ptr_d;
    logic [TCNT_W-1:0]   to_cnt, to_cnt_d;
    logic [N-1:0]        partial, partial_d;
    logic [N-1:0]        dout_d, dac_d;
    logic                valid_d, overrun_d, err_d;
    logic                sample_d, strobe_d, busy_d;

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            samp_cnt      <= '0;
            ptr           <= '0;
            to_cnt        <= '0;
            partial       <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            overrun       <= 1'b0;
            err_timeout   <= 1'b0;
            ms_adc_sample <= 1'b0;
            ms_adc_clk    <= 1'b0;
            ms_adc_dac    <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            samp_cnt      <= samp_cnt_d;
            ptr           <= ptr_d;
            to_cnt        <= to_cnt_d;
            partial       <= partial_d;
            dout          <= dout_d;
            dout_valid    <= valid_d;
            overrun       <= overrun_d;
            err_timeout   <= err_d;
            ms_adc_sample <= sample_d;
            ms_adc_clk    <= strobe_d;
            ms_adc_dac    <= dac_d;
            busy          <= busy_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step
    always_comb begin
        state_d    = state;
        samp_cnt_d = samp_cnt;
        ptr_d      = ptr;
        to_cnt_d   = to_cnt;
        partial_d  = partial;
        dout_d     = dout;
        valid_d    = dout_valid & ~dout_ready;
        overrun_d  = overrun & ~clr_flags;
        err_d      = err_timeout & ~clr_flags;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SAMPLE;
                    samp_cnt_d = SCNT_W'(SAMPLE_CYCLES);
                end
            end
            ST_SAMPLE: begin
                if (samp_cnt <= SCNT_W'(1)) begin
                    state_d   = ST_STROBE;
                    ptr_d     = PTR_W'(N - 1);
                    partial_d = '0;
                end else begin
                    samp_cnt_d = samp_cnt - SCNT_W'(1);
                end
            end
            ST_STROBE: begin
                state_d  = ST_WAIT;
                to_cnt_d = '0;
            end
            ST_WAIT: begin
                if (ms_adc_rdy) begin
                    partial_d[ptr] = ms_adc_cmp;
                    if (ptr != '0) begin
                        ptr_d   = ptr - PTR_W'(1);
                        state_d = ST_STROBE;
                    end else begin
                        dout_d  = partial_d;
                        valid_d = 1'b1;
                        // a pending result that is not being taken this cycle gets lost
                        if (dout_valid && !dout_ready) begin
                            overrun_d = 1'b1;
                        end
                        if (cont) begin
                            state_d    = ST_SAMPLE;
                            samp_cnt_d = SCNT_W'(SAMPLE_CYCLES);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (to_cnt == TCNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt + TCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sample_d = (state_d == ST_SAMPLE);
        strobe_d = (state_d == ST_STROBE);
        busy_d   = (state_d != ST_IDLE);

        case (state_d)
            ST_STROBE: dac_d = partial_d | (BIT0 << ptr_d);
            ST_WAIT:   dac_d = ms_adc_dac;
            default:   dac_d = '0;
        endcase
    end

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Directed bench for adc_sar_ctrl with a behavioural comparator model.
module tb_adc_sar_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, cont, clr_flags;
    logic        ms_adc_sample, ms_adc_clk, ms_adc_rdy, ms_adc_cmp;
    logic [11:0] ms_adc_dac, dout;
    logic        dout_valid, dout_ready, busy, overrun, err_timeout;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    // comparator model state
    logic [11:0] target = 12'hA5C;
    int          lat    = 1;
    int          pend   = 0;
    int          nstrobe = 0;
    logic [11:0] trial_cur = '0;
    logic [11:0] trials [64];

    adc_sar_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cont          (cont),
        .clr_flags     (clr_flags),
        .ms_adc_sample (ms_adc_sample),
        .ms_adc_dac    (ms_adc_dac),
        .ms_adc_clk    (ms_adc_clk),
        .ms_adc_rdy    (ms_adc_rdy),
        .ms_adc_cmp    (ms_adc_cmp),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .busy          (busy),
        .overrun       (overrun),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    // rdy arrives lat cycles after the strobe; lat == 0 means never
    always @(negedge clk) begin
        ms_adc_rdy = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                ms_adc_rdy = 1'b1;
                ms_adc_cmp = (target >= trial_cur);
            end
        end
        if (ms_adc_clk === 1'b1) begin
            trial_cur = ms_adc_dac;
            trials[nstrobe % 64] = ms_adc_dac;
            nstrobe = nstrobe + 1;
            if (lat > 0) pend = lat;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // start is sampled at the edge ending cycle 0; returns positioned in cycle 1
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_valid();
        while (!dout_valid && cyc < 200) step();
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
    endtask

    initial begin
        int base;
        int nvalid;
        rst = 1'b1; start = 1'b0; cont = 1'b0; clr_flags = 1'b0; dout_ready = 1'b1;
        ms_adc_rdy = 1'b0; ms_adc_cmp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({busy, ms_adc_sample, ms_adc_clk, ms_adc_dac, dout,
                                    dout_valid, overrun, err_timeout}), 32'h0);
        rst = 1'b0;

        // basic conversion of A5C
        base = nstrobe;
        pulse_start();
        check("busy_c1", 32'(busy), 32'h1);
        check("sample_c1", 32'(ms_adc_sample), 32'h1);
        while (cyc < 5) step();
        check("strobe_c5", 32'(ms_adc_clk), 32'h1);
        check("sample_c5", 32'(ms_adc_sample), 32'h0);
        wait_valid();
        check("lat_a5c", 32'(cyc), 32'd29);
        check("dout_a5c", 32'(dout), 32'hA5C);
        check("nstrobe_a5c", 32'(nstrobe - base), 32'd12);
        check("trial0", 32'(trials[(base + 0) % 64]), 32'h800);
        check("trial1", 32'(trials[(base + 1) % 64]), 32'hC00);
        check("trial2", 32'(trials[(base + 2) % 64]), 32'hA00);
        check("trial3", 32'(trials[(base + 3) % 64]), 32'hB00);
        check("trial4", 32'(trials[(base + 4) % 64]), 32'hA80);
        step();
        check("valid_consumed", 32'(dout_valid), 32'h0);
        check("idle_after", 32'(busy), 32'h0);

        // extreme targets
        target = 12'h000;
        base = nstrobe;
        pulse_start();
        wait_valid();
        check("lat_zero", 32'(cyc), 32'd29);
        check("dout_zero", 32'(dout), 32'h000);
        check("last_trial_zero", 32'(trials[(base + 11) % 64]), 32'h001);
        target = 12'hFFF;
        base = nstrobe;
        pulse_start();
        wait_valid();
        check("dout_full", 32'(dout), 32'hFFF);
        check("last_trial_full", 32'(trials[(base + 11) % 64]), 32'hFFF);

        // slow comparator
        target = 12'hA5C;
        lat = 3;
        pulse_start();
        wait_valid();
        check("lat_slow", 32'(cyc), 32'd53);
        check("dout_slow", 32'(dout), 32'hA5C);

        // comparator never answers
        lat = 0;
        pulse_start();
        while (!err_timeout && cyc < 100) step();
        check("timeout_cycle", 32'(cyc), 32'd22);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_valid", 32'(dout_valid), 32'h0);
        pulse_clr();
        check("timeout_clr", 32'(err_timeout), 32'h0);
        lat = 1;

        // continuous mode with a stalled consumer
        dout_ready = 1'b0;
        cont = 1'b1;
        pulse_start();
        wait_valid();
        check("cont_lat1", 32'(cyc), 32'd29);
        check("cont_no_ovr_yet", 32'(overrun), 32'h0);
        cont = 1'b0;
        target = 12'h123;
        while (dout !== 12'h123 && cyc < 200) step();
        check("cont_lat2", 32'(cyc), 32'd57);
        check("cont_overrun", 32'(overrun), 32'h1);
        check("cont_valid", 32'(dout_valid), 32'h1);
        repeat (3) step();
        check("cont_stopped", 32'(busy), 32'h0);
        pulse_clr();
        check("overrun_clr", 32'(overrun), 32'h0);
        dout_ready = 1'b1;
        step();
        check("drain_valid", 32'(dout_valid), 32'h0);

        // continuous mode with an always-ready consumer
        target = 12'hA5C;
        cont = 1'b1;
        pulse_start();
        wait_valid();
        cont = 1'b0;
        step();
        while (!dout_valid && cyc < 200) step();
        check("cont_rdy_lat2", 32'(cyc), 32'd57);
        check("cont_rdy_no_ovr", 32'(overrun), 32'h0);

        // reset in the middle of bit 6
        pulse_start();
        while (cyc < 15) step();
        check("bit6_strobe", 32'(ms_adc_clk), 32'h1);
        rst = 1'b1;
        step();
        check("midreset_outputs", 32'({busy, ms_adc_sample, ms_adc_clk, ms_adc_dac, dout,
                                       dout_valid, overrun, err_timeout}), 32'h0);
        rst = 1'b0;
        target = 12'h5A3;
        pulse_start();
        wait_valid();
        check("post_reset_lat", 32'(cyc), 32'd29);
        check("post_reset_dout", 32'(dout), 32'h5A3);

        // start pulses while busy are ignored
        target = 12'h3C3;
        base = nstrobe;
        pulse_start();
        while (cyc < 3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid();
        check("busy_start_lat", 32'(cyc), 32'd29);
        check("busy_start_dout", 32'(dout), 32'h3C3);
        nvalid = 0;
        repeat (60) begin
            step();
            if (dout_valid) nvalid++;
        end
        check("single_result", 32'(nvalid), 32'd0);
        check("single_strobes", 32'(nstrobe - base), 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
